// File: rtl/mist1032isa_sync_fifo_flag_if.sv
// Handshake/status bundle for mist1032isa_sync_fifo_flag.
// The master side pushes and pops; the slave side is the FIFO.
interface mist1032isa_sync_fifo_flag_if #(
  parameter int N   = 16,
  parameter int D_N = 4
);
  logic           iWR_EN;
  logic [N-1:0]   iWR_DATA;
  logic           oWR_FULL;
  logic           oWR_ALMOST_FULL;
  logic           iRD_EN;
  logic [N-1:0]   oRD_DATA;
  logic           oRD_EMPTY;
  logic           oRD_ALMOST_EMPTY;
  logic [D_N:0]   oCOUNT;
  logic           oOVERFLOW;
  logic           oUNDERFLOW;

  modport master (
    output iWR_EN, iWR_DATA, iRD_EN,
    input  oWR_FULL, oWR_ALMOST_FULL, oRD_DATA, oRD_EMPTY,
           oRD_ALMOST_EMPTY, oCOUNT, oOVERFLOW, oUNDERFLOW
  );

  modport slave (
    input  iWR_EN, iWR_DATA, iRD_EN,
    output oWR_FULL, oWR_ALMOST_FULL, oRD_DATA, oRD_EMPTY,
           oRD_ALMOST_EMPTY, oCOUNT, oOVERFLOW, oUNDERFLOW
  );
endinterface

// File: rtl/mist1032isa_sync_fifo_flag.sv
// Single-clock first-word-fall-through FIFO with count and almost-full/empty thresholds.
// Define MIST1032ISA_SYNC_FIFO_ERRFLAG_EN to get sticky overflow/underflow flags.
module mist1032isa_sync_fifo_flag #(
  parameter int N        = 16,
  parameter int DEPTH    = 16,
  parameter int D_N      = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic                          iCLOCK,
  input  logic                          inRESET,
  input  logic                          iREMOVE,
  mist1032isa_sync_fifo_flag_if.slave   fifo
);

  localparam logic [D_N:0] DEPTH_C = (D_N+1)'(DEPTH);
  localparam logic [D_N:0] AF_C    = (D_N+1)'(AF_LEVEL);
  localparam logic [D_N:0] AE_C    = (D_N+1)'(AE_LEVEL);

  logic [N-1:0] mem [DEPTH];
  logic [D_N:0] wp;
  logic [D_N:0] rp;
  logic [D_N:0] count;
  logic         full;
  logic         empty;
  logic         rd_accept;
  logic         wr_accept;

  // The extra pointer bit separates full from empty when the indices coincide.
  assign count     = wp - rp;
  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign rd_accept = fifo.iRD_EN & ~empty;
  assign wr_accept = fifo.iWR_EN & (~full | rd_accept);

  assign fifo.oCOUNT           = count;
  assign fifo.oWR_FULL         = full;
  assign fifo.oWR_ALMOST_FULL  = (count >= AF_C);
  assign fifo.oRD_EMPTY        = empty;
  assign fifo.oRD_ALMOST_EMPTY = (count <= AE_C);
  assign fifo.oRD_DATA         = mem[rp[D_N-1:0]];

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wp <= '0;
      rp <= '0;
    end else if (iREMOVE) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_accept) wp <= wp + 1'b1;
      if (rd_accept) rp <= rp + 1'b1;
    end
  end

  // Storage carries no reset; a flush only rewinds the pointers.
  always_ff @(posedge iCLOCK) begin
    if (!iREMOVE && wr_accept) mem[wp[D_N-1:0]] <= fifo.iWR_DATA;
  end

`ifdef MIST1032ISA_SYNC_FIFO_ERRFLAG_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (iREMOVE) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (fifo.iWR_EN && !wr_accept) overflow_q  <= 1'b1;
      if (fifo.iRD_EN && !rd_accept) underflow_q <= 1'b1;
    end
  end

  assign fifo.oOVERFLOW  = overflow_q;
  assign fifo.oUNDERFLOW = underflow_q;
`else
  assign fifo.oOVERFLOW  = 1'b0;
  assign fifo.oUNDERFLOW = 1'b0;
`endif

endmodule
